// File: rtl/obi_wb_arbiter_bridge.sv
// Arbitrates N OBI request ports onto one Wishbone classic master port, one transfer in flight.
// A watchdog turns a missing ack into an OBI error response so the requesting core cannot hang.
module obi_wb_arbiter_bridge #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS-1:0]               obi_req_i,
  output logic [NUM_MASTERS-1:0]               obi_gnt_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    obi_addr_i,
  input  logic [NUM_MASTERS-1:0]               obi_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  obi_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    obi_wdata_i,
  output logic [NUM_MASTERS-1:0]               obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]                obi_rdata_o,
  output logic                                 obi_err_o,
  output logic                                 wb_cyc_o,
  output logic                                 wb_stb_o,
  output logic                                 wb_we_o,
  output logic [DATA_WIDTH/8-1:0]              wb_sel_o,
  output logic [ADDR_WIDTH-1:0]                wb_addr_o,
  output logic [DATA_WIDTH-1:0]                wb_data_o,
  input  logic [DATA_WIDTH-1:0]                wb_data_i,
  input  logic                                 wb_ack_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Handshake: a master holds req until it sees gnt in the same cycle; the
  // response is a single-cycle rvalid to the owner, and rdata/err stay stable after it.
  logic [1:0]             state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       rr_ptr;
  logic [WD_W-1:0]        wd_cnt;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic                   lat_we;
  logic [BE_W-1:0]        lat_be;
  logic [DATA_WIDTH-1:0]  lat_wdata;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   err_q;

  logic                   any_req;
  logic                   rr_found;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W:0]         rr_sum;
  logic [IDX_W:0]         ptr_nxt;
  logic [2*NUM_MASTERS-1:0] req_rot;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_we;
  logic [BE_W-1:0]        sel_be;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  // Round-robin rotates the request vector so bit 0 is the pointer position.
  always_comb begin
    any_req  = |obi_req_i;
    winner   = '0;
    rr_found = 1'b0;
    rr_sum   = '0;
    req_rot  = {obi_req_i, obi_req_i} >> rr_ptr;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (obi_req_i[i]) winner = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!rr_found && req_rot[i]) begin
          rr_found = 1'b1;
          rr_sum   = {1'b0, rr_ptr} + (IDX_W+1)'(i);
          if (rr_sum >= (IDX_W+1)'(NUM_MASTERS))
            rr_sum = rr_sum - (IDX_W+1)'(NUM_MASTERS);
          winner = rr_sum[IDX_W-1:0];
        end
      end
    end
    ptr_nxt = {1'b0, winner} + (IDX_W+1)'(1);
    if (ptr_nxt >= (IDX_W+1)'(NUM_MASTERS)) ptr_nxt = '0;
  end

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_addr  = obi_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_we    = obi_we_i[i];
        sel_be    = obi_be_i[i*BE_W +: BE_W];
        sel_wdata = obi_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner     <= winner;
            lat_addr  <= sel_addr;
            lat_we    <= sel_we;
            lat_be    <= sel_be;
            lat_wdata <= sel_wdata;
            wd_cnt    <= '0;
            if (ARB_MODE != 0) rr_ptr <= ptr_nxt[IDX_W-1:0];
            state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Ack has priority over a watchdog expiring in the same cycle.
          if (wb_ack_i) begin
            rdata_q <= lat_we ? '0 : wb_data_i;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (TIMEOUT != 0 && wd_cnt == WD_W'(TIMEOUT - 1)) begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Grant is combinational from IDLE and forced low while reset is held.
  always_comb begin
    obi_gnt_o    = '0;
    obi_rvalid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      obi_gnt_o[i]    = !rst && state == ST_IDLE && any_req && winner == IDX_W'(i);
      obi_rvalid_o[i] = state == ST_RESP && owner == IDX_W'(i);
    end
  end

  assign wb_cyc_o    = (state == ST_ACTIVE);
  assign wb_stb_o    = (state == ST_ACTIVE);
  assign wb_we_o     = lat_we;
  assign wb_sel_o    = lat_be;
  assign wb_addr_o   = lat_addr;
  assign wb_data_o   = lat_wdata;
  assign obi_rdata_o = rdata_q;
  assign obi_err_o   = err_q;

endmodule

// File: tb/tb_obi_wb_arbiter_bridge.sv
// Directed bench: instance a is round-robin, instance b is fixed priority; both use an 8-cycle watchdog.
module tb_obi_wb_arbiter_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] addr;
  logic [1:0]  we;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic [31:0] wb_di;
  logic        ack;

  logic [1:0]  a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata, a_waddr, b_waddr, a_wdo, b_wdo;
  logic        a_err, b_err, a_cyc, b_cyc, a_stb, b_stb, a_wwe, b_wwe;
  logic [3:0]  a_sel, b_sel;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_b_q[$];
  logic [1:0] g;
  logic [1:0] seen;
  int cnt;

  always #5 clk = ~clk;

  obi_wb_arbiter_bridge #(.NUM_MASTERS(2), .ARB_MODE(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .obi_req_i(req), .obi_gnt_o(a_gnt), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(a_rvalid),
    .obi_rdata_o(a_rdata), .obi_err_o(a_err), .wb_cyc_o(a_cyc), .wb_stb_o(a_stb),
    .wb_we_o(a_wwe), .wb_sel_o(a_sel), .wb_addr_o(a_waddr), .wb_data_o(a_wdo),
    .wb_data_i(wb_di), .wb_ack_i(ack)
  );

  obi_wb_arbiter_bridge #(.NUM_MASTERS(2), .ARB_MODE(0), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .obi_req_i(req), .obi_gnt_o(b_gnt), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(b_rvalid),
    .obi_rdata_o(b_rdata), .obi_err_o(b_err), .wb_cyc_o(b_cyc), .wb_stb_o(b_stb),
    .wb_we_o(b_wwe), .wb_sel_o(b_sel), .wb_addr_o(b_waddr), .wb_data_o(b_wdo),
    .wb_data_i(wb_di), .wb_ack_i(ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d);
    req[m]            = 1'b1;
    addr[m*32 +: 32]  = a;
    we[m]             = w;
    be[m*4 +: 4]      = b;
    wdata[m*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; req = 2'b11; addr = '0; we = '0; be = '0; wdata = '0; wb_di = '0; ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", a_gnt, 2'b00);
    check("rst_cyc", a_cyc, 1'b0);
    check("rst_rvalid", a_rvalid, 2'b00);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Read from master 1 with an immediate ack.
    @(negedge clk);
    drive(1, 32'h100, 1'b0, 4'hF, 32'h0);
    #1 check("t1_gnt", a_gnt, 2'b10);
    @(negedge clk);
    req = 2'b00;
    #1;
    check("t1_cyc", a_cyc, 1'b1);
    check("t1_stb", a_stb, 1'b1);
    check("t1_addr", a_waddr, 32'h100);
    check("t1_we", a_wwe, 1'b0);
    check("t1_gnt_active", a_gnt, 2'b00);
    ack = 1'b1; wb_di = 32'hCAFEF00D;
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("t1_rvalid", a_rvalid, 2'b10);
    check("t1_rdata", a_rdata, 32'hCAFEF00D);
    check("t1_err", a_err, 1'b0);
    check("t1_cyc_drop", a_cyc, 1'b0);
    @(negedge clk);
    #1;
    check("t1_rvalid_once", a_rvalid, 2'b00);
    check("t1_rdata_hold", a_rdata, 32'hCAFEF00D);

    // Partial-byte write from master 0.
    @(negedge clk);
    drive(0, 32'h40, 1'b1, 4'b0011, 32'h12345678);
    #1 check("t2_gnt", a_gnt, 2'b01);
    @(negedge clk);
    req = 2'b00;
    #1;
    check("t2_we", a_wwe, 1'b1);
    check("t2_sel", a_sel, 4'b0011);
    check("t2_data", a_wdo, 32'h12345678);
    check("t2_addr", a_waddr, 32'h40);
    ack = 1'b1; wb_di = 32'hFFFFFFFF;
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("t2_rvalid", a_rvalid, 2'b01);
    check("t2_rdata_zero", a_rdata, 32'h0);
    check("t2_err", a_err, 1'b0);
    @(negedge clk);
    #1 check("t2_rvalid_once", a_rvalid, 2'b00);

    // Zero byte enables pass straight through.
    @(negedge clk);
    drive(0, 32'h44, 1'b1, 4'b0000, 32'hA5A5A5A5);
    #1 check("be0_gnt", a_gnt, 2'b01);
    @(negedge clk);
    req = 2'b00;
    #1;
    check("be0_sel", a_sel, 4'b0000);
    check("be0_data", a_wdo, 32'hA5A5A5A5);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1 check("be0_rvalid", a_rvalid, 2'b01);

    // Stray ack while idle must not create a response.
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("stray_rvalid", a_rvalid, 2'b00);
    check("stray_cyc", a_cyc, 1'b0);
    @(negedge clk);
    #1 check("stray_rvalid2", a_rvalid, 2'b00);

    // Arbitration order from a fresh pointer with both masters requesting.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    for (int k = 0; k < 4; k++) exp_b_q.push_back(2'b10);
    @(negedge clk);
    drive(0, 32'h1000, 1'b0, 4'hF, 32'h0);
    drive(1, 32'h2000, 1'b0, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      g = exp_q.pop_front();
      check("arb_rr_gnt", a_gnt, g);
      check("arb_fix_gnt", b_gnt, exp_b_q.pop_front());
      @(negedge clk);
      #1 ack = 1'b1; wb_di = 32'(k);
      @(negedge clk);
      ack = 1'b0;
      #1;
      check("arb_rr_rvalid", a_rvalid, g);
      check("arb_fix_rvalid", b_rvalid, 2'b10);
      @(negedge clk);
    end
    req = 2'b00;

    // Watchdog expiry with no ack.
    @(negedge clk);
    drive(1, 32'h200, 1'b0, 4'hF, 32'h0);
    #1 check("to_gnt", a_gnt, 2'b10);
    cnt = 0;
    @(negedge clk);
    req = 2'b00;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!a_cyc) break;
      cnt++;
      @(negedge clk);
    end
    check("to_active_cycles", 64'(cnt), 64'd8);
    check("to_rvalid", a_rvalid, 2'b10);
    check("to_err", a_err, 1'b1);
    check("to_rdata", a_rdata, 32'hDEADBEEF);

    // Ack in the same cycle the watchdog expires.
    @(negedge clk);
    drive(1, 32'h300, 1'b0, 4'hF, 32'h0);
    #1 check("tie_gnt", a_gnt, 2'b10);
    @(negedge clk);
    req = 2'b00;
    repeat (7) @(negedge clk);
    ack = 1'b1; wb_di = 32'h5555AAAA;
    #1 check("tie_cyc_last", a_cyc, 1'b1);
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("tie_rvalid", a_rvalid, 2'b10);
    check("tie_err", a_err, 1'b0);
    check("tie_rdata", a_rdata, 32'h5555AAAA);

    // Reset in the middle of an active transfer.
    @(negedge clk);
    drive(0, 32'h500, 1'b1, 4'b1100, 32'h77778888);
    #1 check("mr_gnt", a_gnt, 2'b01);
    @(negedge clk);
    req = 2'b00;
    #1 check("mr_cyc", a_cyc, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_cyc0", a_cyc, 1'b0);
    check("mr_stb0", a_stb, 1'b0);
    check("mr_addr0", a_waddr, 32'h0);
    check("mr_sel0", a_sel, 4'h0);
    check("mr_we0", a_wwe, 1'b0);
    check("mr_wdata0", a_wdo, 32'h0);
    check("mr_rdata0", a_rdata, 32'h0);
    check("mr_err0", a_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1 seen = seen | a_rvalid;
      @(negedge clk);
    end
    check("mr_no_rvalid", seen, 2'b00);
    drive(0, 32'h80, 1'b0, 4'hF, 32'h0);
    #1 check("mr_next_gnt", a_gnt, 2'b01);
    @(negedge clk);
    req = 2'b00;
    #1 check("mr_next_addr", a_waddr, 32'h80);
    ack = 1'b1; wb_di = 32'h0BADF00D;
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("mr_next_rvalid", a_rvalid, 2'b01);
    check("mr_next_rdata", a_rdata, 32'h0BADF00D);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
